// File: rtl/pcie_os_pkg.sv
// Shared ordered-set encodings, scheduler states and generation constants.
package pcie_os_pkg;

   // Ordered-set type presented to the downstream OS generator
   typedef enum logic [2:0] {
      OsNone  = 3'd0,
      OsTs1   = 3'd1,
      OsTs2   = 3'd2,
      OsSkp   = 3'd3,
      OsEios  = 3'd4,
      OsEieos = 3'd5
   } os_type_e;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StTsBurst  = 2'd1,
      StElecIdle = 2'd2
   } sched_state_e;

   // First generation that needs EIEOS framing around TS1 bursts
   localparam logic [2:0] GEN3 = 3'd3;

   function automatic logic is_ts(input os_type_e t);
      return (t == OsTs1) || (t == OsTs2);
   endfunction

endpackage

// File: rtl/skp_timer.sv
// SKP interval timer with a single-entry pending flag.
module skp_timer #(
   parameter int unsigned Interval = 370
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_hold,
   input  logic i_flush,
   input  logic i_clr,
   output logic o_pending
);

   localparam int unsigned CntW = (Interval > 1) ? $clog2(Interval) : 1;

   logic [CntW-1:0] r_cnt;
   logic            r_pending;
   logic            w_expire;

   assign w_expire  = r_cnt == CntW'(Interval - 1);
   assign o_pending = r_pending;

   // Free-running count outside electrical idle; expiry while pending does not stack.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_cnt     <= '0;
         r_pending <= 1'b0;
      end else if (i_flush) begin
         r_cnt     <= '0;
         r_pending <= 1'b0;
      end else if (i_hold) begin
         r_cnt     <= '0;
      end else begin
         r_cnt     <= w_expire ? '0 : r_cnt + CntW'(1);
         // Expiry wins over a coinciding SKP accept
         r_pending <= w_expire | (r_pending & ~i_clr);
      end
   end

endmodule

// File: rtl/os_tx_scheduler.sv
// Ordered-set transmit scheduler: arbitrates EIOS > SKP > EIEOS > TS onto a
// valid/ready request channel and tracks TS bursts.
module os_tx_scheduler
   import pcie_os_pkg::*;
#(
   parameter int unsigned SKP_INTERVAL   = 370,
   parameter int unsigned EIEOS_INTERVAL = 32,
   parameter int unsigned COUNT_W        = 11
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [2:0]         gen,
   input  logic               tsReq,
   input  logic               tsType,
   input  logic [COUNT_W-1:0] tsCount,
   input  logic               eiosReq,
   input  logic               osReady,
   output logic               osValid,
   output logic [2:0]         osType,
   output logic               tsDone,
   output logic               eiosDone,
   output logic               skpPending
);

   localparam int unsigned EiW = (EIEOS_INTERVAL < 1) ? 1 : $clog2(EIEOS_INTERVAL + 1);

   sched_state_e       r_state, w_state_d;
   logic               r_os_valid, w_os_valid_d;
   os_type_e           r_os_type, w_os_type_d;
   logic               r_ts_type, w_ts_type_d;
   logic [COUNT_W-1:0] r_count, w_count_d;
   logic [COUNT_W-1:0] r_sent, w_sent_d;
   logic [EiW-1:0]     r_ts1_cnt, w_ts1_cnt_d;
   logic               r_first, w_first_d;
   logic               r_eios_pend, w_eios_pend_d;
   logic               r_ts_done, w_ts_done_d;
   logic               r_eios_done;

   logic w_accept, w_decide, w_acc_ts, w_acc_ts1, w_acc_skp, w_acc_eios, w_acc_eieos;
   logic w_burst_end, w_start, w_need_eieos, w_skp_pending, w_hold;

   assign w_accept    = r_os_valid & osReady;
   assign w_decide    = ~r_os_valid | osReady;
   assign w_acc_ts    = w_accept & is_ts(r_os_type);
   assign w_acc_ts1   = w_accept & (r_os_type == OsTs1);
   assign w_acc_skp   = w_accept & (r_os_type == OsSkp);
   assign w_acc_eios  = w_accept & (r_os_type == OsEios);
   assign w_acc_eieos = w_accept & (r_os_type == OsEieos);
   assign w_burst_end = w_acc_ts & (r_count != '0) & ((r_sent + COUNT_W'(1)) == r_count);
   assign w_hold      = r_state == StElecIdle;

   skp_timer #(
      .Interval (SKP_INTERVAL)
   ) u_skp_timer (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_hold    (w_hold),
      .i_flush   (w_acc_eios),
      .i_clr     (w_acc_skp),
      .o_pending (w_skp_pending)
   );

   // Next-state: burst bookkeeping, state transitions, then arbitration at decision points.
   always_comb begin
      w_state_d     = r_state;
      w_ts_type_d   = r_ts_type;
      w_count_d     = r_count;
      w_sent_d      = r_sent;
      w_ts1_cnt_d   = r_ts1_cnt;
      w_first_d     = r_first;
      w_ts_done_d   = 1'b0;
      w_os_valid_d  = r_os_valid;
      w_os_type_d   = r_os_type;
      w_start       = 1'b0;
      // Requests arriving in electrical idle are already satisfied
      w_eios_pend_d = (r_eios_pend | (eiosReq & (r_state != StElecIdle))) & ~w_acc_eios;

      if (w_acc_ts) w_sent_d = r_sent + COUNT_W'(1);
      if (w_acc_ts1 && (r_ts1_cnt < EiW'(EIEOS_INTERVAL))) w_ts1_cnt_d = r_ts1_cnt + EiW'(1);
      if (w_acc_eieos) begin
         w_ts1_cnt_d = '0;
         w_first_d   = 1'b0;
      end

      unique case (r_state)
         StIdle: begin
            if (w_acc_eios) w_state_d = StElecIdle;
            else if (tsReq) w_start = 1'b1;
         end
         StTsBurst: begin
            if (w_acc_eios) begin
               w_state_d = StElecIdle;
            end else if (w_burst_end) begin
               w_state_d   = StIdle;
               w_ts_done_d = 1'b1;
            end else if (!tsReq && w_decide) begin
               w_state_d = StIdle;
            end
         end
         StElecIdle: begin
            if (tsReq) w_start = 1'b1;
         end
         default: w_state_d = StIdle;
      endcase

      if (w_start) begin
         w_state_d   = StTsBurst;
         w_ts_type_d = tsType;
         w_count_d   = tsCount;
         w_sent_d    = '0;
         w_ts1_cnt_d = '0;
         w_first_d   = 1'b1;
      end

      w_need_eieos = !w_ts_type_d && (gen >= GEN3) &&
                     (w_first_d || (w_ts1_cnt_d >= EiW'(EIEOS_INTERVAL)));

      if (w_decide) begin
         w_os_valid_d = 1'b0;
         w_os_type_d  = OsNone;
         if (w_state_d != StElecIdle) begin
            if (w_eios_pend_d) begin
               w_os_valid_d = 1'b1;
               w_os_type_d  = OsEios;
            end else if (w_skp_pending && !w_acc_skp) begin
               w_os_valid_d = 1'b1;
               w_os_type_d  = OsSkp;
            end else if (w_state_d == StTsBurst && w_need_eieos) begin
               w_os_valid_d = 1'b1;
               w_os_type_d  = OsEieos;
            end else if (w_state_d == StTsBurst) begin
               w_os_valid_d = 1'b1;
               w_os_type_d  = w_ts_type_d ? OsTs2 : OsTs1;
            end
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= StIdle;
         r_os_valid  <= 1'b0;
         r_os_type   <= OsNone;
         r_ts_type   <= 1'b0;
         r_count     <= '0;
         r_sent      <= '0;
         r_ts1_cnt   <= '0;
         r_first     <= 1'b0;
         r_eios_pend <= 1'b0;
         r_ts_done   <= 1'b0;
         r_eios_done <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_os_valid  <= w_os_valid_d;
         r_os_type   <= w_os_type_d;
         r_ts_type   <= w_ts_type_d;
         r_count     <= w_count_d;
         r_sent      <= w_sent_d;
         r_ts1_cnt   <= w_ts1_cnt_d;
         r_first     <= w_first_d;
         r_eios_pend <= w_eios_pend_d;
         r_ts_done   <= w_ts_done_d;
         r_eios_done <= w_acc_eios;
      end
   end

   assign osValid    = r_os_valid;
   assign osType     = r_os_type;
   assign tsDone     = r_ts_done;
   assign eiosDone   = r_eios_done;
   assign skpPending = w_skp_pending;

endmodule

// File: tb/tb_os_tx_scheduler.sv
// Bench for os_tx_scheduler: two instances (long and short SKP interval) share
// stimulus; a behavioural model predicts every output each cycle.
module tb_os_tx_scheduler;

   localparam int CW    = 11;
   localparam int EI    = 32;
   localparam int SKP_A = 4000;
   localparam int SKP_B = 8;
   localparam int T_NONE = 0, T_TS1 = 1, T_TS2 = 2, T_SKP = 3, T_EIOS = 4, T_EIEOS = 5;
   localparam int M_IDLE = 0, M_BURST = 1, M_ELEC = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [2:0]    gen;
   logic          ts_req, ts_type, eios_req, os_ready;
   logic [CW-1:0] ts_count;
   logic          d_valid     [2];
   logic [2:0]    d_type      [2];
   logic          d_ts_done   [2];
   logic          d_eios_done [2];
   logic          d_skp       [2];

   always #5 clk = ~clk;

   os_tx_scheduler #(.SKP_INTERVAL(SKP_A), .EIEOS_INTERVAL(EI), .COUNT_W(CW)) u_dut_a (
      .clk(clk), .reset(reset), .gen(gen), .tsReq(ts_req), .tsType(ts_type),
      .tsCount(ts_count), .eiosReq(eios_req), .osReady(os_ready),
      .osValid(d_valid[0]), .osType(d_type[0]), .tsDone(d_ts_done[0]),
      .eiosDone(d_eios_done[0]), .skpPending(d_skp[0])
   );

   os_tx_scheduler #(.SKP_INTERVAL(SKP_B), .EIEOS_INTERVAL(EI), .COUNT_W(CW)) u_dut_b (
      .clk(clk), .reset(reset), .gen(gen), .tsReq(ts_req), .tsType(ts_type),
      .tsCount(ts_count), .eiosReq(eios_req), .osReady(os_ready),
      .osValid(d_valid[1]), .osType(d_type[1]), .tsDone(d_ts_done[1]),
      .eiosDone(d_eios_done[1]), .skpPending(d_skp[1])
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model state per instance
   int m_mode [2];
   bit m_valid [2];
   int m_type [2];
   bit m_ts_done [2];
   bit m_eios_done [2];
   bit m_skp_due [2];
   int m_timer [2];
   bit m_eios_req [2];
   int m_btype [2];
   int m_len [2];
   int m_sent [2];
   int m_since [2];
   bit m_first [2];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset(input int k);
      m_mode[k] = M_IDLE; m_valid[k] = 0; m_type[k] = T_NONE;
      m_ts_done[k] = 0; m_eios_done[k] = 0; m_skp_due[k] = 0; m_timer[k] = 0;
      m_eios_req[k] = 0; m_btype[k] = T_TS1; m_len[k] = 0; m_sent[k] = 0;
      m_since[k] = 0; m_first[k] = 0;
   endtask

   task automatic start_burst(input int k);
      m_mode[k]  = M_BURST;
      m_btype[k] = ts_type ? T_TS2 : T_TS1;
      m_len[k]   = int'(ts_count);
      m_sent[k]  = 0;
      m_since[k] = 0;
      m_first[k] = 1;
   endtask

   // One clock of the scheduler as described by its rules
   task automatic model_step(input int k);
      bit acc, decide, skp_avail, acc_ts;
      int t, skp_int;
      t         = m_type[k];
      acc       = m_valid[k] && os_ready;
      decide    = !m_valid[k] || os_ready;
      acc_ts    = acc && (t == T_TS1 || t == T_TS2);
      skp_int   = (k == 0) ? SKP_A : SKP_B;
      skp_avail = m_skp_due[k] && !(acc && t == T_SKP);
      m_ts_done[k]   = 0;
      m_eios_done[k] = acc && t == T_EIOS;
      if (eios_req && m_mode[k] != M_ELEC) m_eios_req[k] = 1;
      if (acc && t == T_EIOS) m_eios_req[k] = 0;
      if (acc && t == T_EIOS) begin
         m_timer[k] = 0; m_skp_due[k] = 0;
      end else if (m_mode[k] == M_ELEC) begin
         m_timer[k] = 0;
      end else if (m_timer[k] == skp_int - 1) begin
         m_timer[k] = 0; m_skp_due[k] = 1;
      end else begin
         m_timer[k]++;
         if (acc && t == T_SKP) m_skp_due[k] = 0;
      end
      if (acc_ts) m_sent[k]++;
      if (acc && t == T_TS1) m_since[k]++;
      if (acc && t == T_EIEOS) begin
         m_since[k] = 0; m_first[k] = 0;
      end
      case (m_mode[k])
         M_IDLE: begin
            if (acc && t == T_EIOS) m_mode[k] = M_ELEC;
            else if (ts_req) start_burst(k);
         end
         M_BURST: begin
            if (acc && t == T_EIOS) m_mode[k] = M_ELEC;
            else if (acc_ts && m_len[k] != 0 && m_sent[k] == m_len[k]) begin
               m_mode[k] = M_IDLE; m_ts_done[k] = 1;
            end else if (!ts_req && decide) m_mode[k] = M_IDLE;
         end
         default: if (ts_req) start_burst(k);
      endcase
      if (decide) begin
         m_valid[k] = 0; m_type[k] = T_NONE;
         if (m_mode[k] != M_ELEC) begin
            m_valid[k] = 1;
            if (m_eios_req[k]) m_type[k] = T_EIOS;
            else if (skp_avail) m_type[k] = T_SKP;
            else if (m_mode[k] == M_BURST && m_btype[k] == T_TS1 && gen >= 3 &&
                     (m_first[k] || m_since[k] >= EI)) m_type[k] = T_EIEOS;
            else if (m_mode[k] == M_BURST) m_type[k] = m_btype[k];
            else m_valid[k] = 0;
         end
      end
   endtask

   task automatic compare();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("osValid[%0d]", k), int'(d_valid[k]), int'(m_valid[k]));
         chk($sformatf("osType[%0d]", k), int'(d_type[k]), m_type[k]);
         chk($sformatf("tsDone[%0d]", k), int'(d_ts_done[k]), int'(m_ts_done[k]));
         chk($sformatf("eiosDone[%0d]", k), int'(d_eios_done[k]), int'(m_eios_done[k]));
         chk($sformatf("skpPending[%0d]", k), int'(d_skp[k]), int'(m_skp_due[k]));
      end
   endtask

   // Advance one clock: model follows the rising edge, outputs compared on the falling edge
   task automatic cycle();
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (!reset) model_reset(k);
         else model_step(k);
      end
      @(negedge clk);
      compare();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_ts1, n_eieos, last_acc, done_cyc, n_done, errs, unstable, rises, held;
      int acc1, acc2, idle_bad;
      bit prev_skp, found;
      int seq[$];

      reset = 0; gen = 3'd1; ts_req = 0; ts_type = 0; ts_count = '0;
      eios_req = 0; os_ready = 1;
      for (int k = 0; k < 2; k++) model_reset(k);
      repeat (3) cycle();
      chk("reset_osValid", int'(d_valid[0]), 0);
      chk("reset_osType", int'(d_type[0]), 0);
      chk("reset_skpPending_b", int'(d_skp[1]), 0);
      reset = 1;
      cycle();

      // gen1 counted TS1 burst of 16
      gen = 3'd1; ts_type = 0; ts_count = CW'(16); ts_req = 1;
      n_ts1 = 0; n_eieos = 0; last_acc = -1; done_cyc = -1; n_done = 0;
      for (int c = 0; c < 40; c++) begin
         cycle();
         if (d_ts_done[0]) begin n_done++; done_cyc = c; end
         if (d_valid[0] && os_ready) begin
            if (d_type[0] == 3'(T_EIEOS)) n_eieos++;
            if (d_type[0] == 3'(T_TS1)) begin n_ts1++; last_acc = c; end
            if (n_ts1 == 16) ts_req = 0;
         end
      end
      chk("gen1_ts1_accepts", n_ts1, 16);
      chk("gen1_no_eieos", n_eieos, 0);
      chk("gen1_done_latency", done_cyc, last_acc + 1);
      chk("gen1_done_pulses", n_done, 1);
      repeat (5) cycle();

      // gen3 continuous TS1: EIEOS framing every 32 TS1
      gen = 3'd3; ts_type = 0; ts_count = '0; ts_req = 1;
      for (int c = 0; c < 120 && seq.size() < 70; c++) begin
         cycle();
         if (d_valid[0] && os_ready) seq.push_back(int'(d_type[0]));
      end
      chk("gen3_accept_count", seq.size(), 70);
      errs = 0;
      for (int i = 0; i < seq.size(); i++)
         if (seq[i] != ((i % 33 == 0) ? T_EIEOS : T_TS1)) errs++;
      chk("gen3_pattern_errors", errs, 0);
      if (seq.size() > 33) chk("gen3_second_eieos", seq[33], T_EIEOS);
      ts_req = 0;
      repeat (6) cycle();

      // SKP interval 8 instance: stall a TS2 for 20 cycles
      gen = 3'd2; ts_type = 1; ts_count = CW'(12); ts_req = 1;
      found = 0;
      for (int c = 0; c < 40 && !found; c++) begin
         cycle();
         if (c >= 2 && d_valid[1] && d_type[1] == 3'(T_TS2) && !d_skp[1]) found = 1;
      end
      chk("stall_start_found", int'(found), 1);
      os_ready = 0;
      held = int'(d_type[1]); unstable = 0; rises = 0; prev_skp = d_skp[1];
      for (int c = 0; c < 20; c++) begin
         cycle();
         if (!d_valid[1] || int'(d_type[1]) != held) unstable++;
         if (d_skp[1] && !prev_skp) rises++;
         prev_skp = d_skp[1];
      end
      chk("stall_type_unstable", unstable, 0);
      chk("stall_skp_rises", rises, 1);
      chk("stall_skp_set", int'(d_skp[1]), 1);
      os_ready = 1;
      acc1 = d_valid[1] ? int'(d_type[1]) : T_NONE;
      cycle();
      acc2 = d_valid[1] ? int'(d_type[1]) : T_NONE;
      chk("release_first_accept", acc1, T_TS2);
      chk("release_then_skp", acc2, T_SKP);
      found = 0;
      for (int c = 0; c < 60 && !found; c++) begin
         cycle();
         if (d_ts_done[1]) begin found = 1; ts_req = 0; end
      end
      chk("short_skp_burst_done", int'(found), 1);
      ts_req = 0;
      repeat (10) cycle();

      // EIOS during a gen4 TS2 burst, then re-entry with TS1
      gen = 3'd4; ts_type = 1; ts_count = '0; ts_req = 1;
      repeat (6) cycle();
      chk("pre_eios_ts2", int'(d_type[0]), T_TS2);
      eios_req = 1;
      cycle();
      eios_req = 0;
      chk("eios_presented", int'(d_type[0]), T_EIOS);
      ts_req = 0;
      cycle();
      chk("eios_done_pulse", int'(d_eios_done[0]), 1);
      idle_bad = 0;
      for (int c = 0; c < 5; c++) begin
         cycle();
         if (d_valid[0] || d_valid[1]) idle_bad++;
      end
      chk("elec_idle_quiet", idle_bad, 0);
      ts_type = 0; ts_req = 1;
      cycle();
      chk("reentry_eieos_first", d_valid[0] ? int'(d_type[0]) : T_NONE, T_EIEOS);
      cycle();
      chk("reentry_then_ts1", int'(d_type[0]), T_TS1);
      ts_req = 0;
      repeat (6) cycle();

      // Reset mid-burst after 5 TS1 accepts
      gen = 3'd1; ts_type = 0; ts_count = CW'(20); ts_req = 1;
      n_ts1 = 0;
      for (int c = 0; c < 30 && n_ts1 < 5; c++) begin
         cycle();
         if (d_valid[0] && os_ready && d_type[0] == 3'(T_TS1)) n_ts1++;
      end
      cycle();
      chk("pre_reset_accepts", n_ts1, 5);
      #2 reset = 0;
      for (int k = 0; k < 2; k++) model_reset(k);
      #1;
      chk("async_rst_valid", int'(d_valid[0]), 0);
      chk("async_rst_type", int'(d_type[0]), 0);
      chk("async_rst_done", int'(d_ts_done[0]) + int'(d_eios_done[0]) + int'(d_skp[0]), 0);
      ts_req = 0;
      cycle();
      reset = 1;
      n_done = 0;
      for (int c = 0; c < 30; c++) begin
         cycle();
         if (d_ts_done[0]) n_done++;
      end
      chk("no_done_after_reset", n_done, 0);

      // Randomized traffic
      for (int c = 0; c < 1500; c++) begin
         if (!reset) reset = 1;
         os_ready = ($urandom_range(0, 9) < 7);
         eios_req = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 19) == 0) gen = 3'($urandom_range(1, 5));
         if ($urandom_range(0, 14) == 0) ts_req = ~ts_req;
         if ($urandom_range(0, 9) == 0) begin
            ts_type  = 1'($urandom_range(0, 1));
            ts_count = ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom_range(1, 20));
         end
         if ($urandom_range(0, 299) == 0) reset = 0;
         cycle();
      end
      reset = 1; ts_req = 0; eios_req = 0;
      repeat (4) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
